// File: rtl/vmul_pkg.sv
// Shared definitions for the multi-pass vector multiply unit: op-field positions,
// FSM state encoding and the pass-pointer width helper.
package vmul_pkg;

   localparam int unsigned OP_SIGNED = 0;
   localparam int unsigned OP_HI     = 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } vmul_state_e;

   // Pointer width for n passes; never below one bit so P=1 still has a legal vector.
   function automatic int unsigned clog2_min1(input int unsigned n);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((32'd1 << i) < n) r = i + 1;
      end
      return (r == 0) ? 1 : r;
   endfunction

endpackage

// File: rtl/vmul_group.sv
// One lane group: NUMMULS multipliers with signed/high-half select.
// VMUL_FXP_SHIFT_EN adds a fixed-point right shift of the full product on the low-half path.
module vmul_group
   import vmul_pkg::*;
#(
   parameter int unsigned NUMMULS   = 4,
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned LOG2WIDTH = 5
) (
   input  logic [NUMMULS*WIDTH-1:0] a,
   input  logic [NUMMULS*WIDTH-1:0] b,
   input  logic                     is_signed,
   input  logic                     is_hi,
`ifdef VMUL_FXP_SHIFT_EN
   input  logic [LOG2WIDTH-1:0]     vshamt,
`endif
   output logic [NUMMULS*WIDTH-1:0] res
);

   logic [2*WIDTH-1:0] ax   [NUMMULS];
   logic [2*WIDTH-1:0] bx   [NUMMULS];
   logic [2*WIDTH-1:0] prod [NUMMULS];

   // Sign-extending to 2*WIDTH lets one unsigned multiplier serve both signednesses.
   always_comb begin
      for (int unsigned i = 0; i < NUMMULS; i++) begin
         ax[i]   = {{WIDTH{a[i*WIDTH+WIDTH-1] & is_signed}}, a[i*WIDTH +: WIDTH]};
         bx[i]   = {{WIDTH{b[i*WIDTH+WIDTH-1] & is_signed}}, b[i*WIDTH +: WIDTH]};
         prod[i] = ax[i] * bx[i];
      end
   end

   always_comb begin
      res = '0;
      for (int unsigned i = 0; i < NUMMULS; i++) begin
         if (is_hi) begin
            res[i*WIDTH +: WIDTH] = prod[i][2*WIDTH-1:WIDTH];
`ifdef VMUL_FXP_SHIFT_EN
         end else if (is_signed) begin
            res[i*WIDTH +: WIDTH] = WIDTH'($signed(prod[i]) >>> vshamt);
         end else begin
            res[i*WIDTH +: WIDTH] = WIDTH'(prod[i] >> vshamt);
`else
         end else begin
            res[i*WIDTH +: WIDTH] = prod[i][WIDTH-1:0];
`endif
         end
      end
   end

endmodule

// File: rtl/vmul_unit_mp.sv
// Vector multiply unit: NUMLANES lanes time-share NUMMULS multipliers over P passes,
// skipping all-masked lane groups. Optional fixed-point shift via VMUL_FXP_SHIFT_EN.
module vmul_unit_mp
   import vmul_pkg::*;
#(
   parameter int unsigned NUMLANES   = 8,
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned LOG2WIDTH  = 5,
   parameter int unsigned NUMMULS    = 4,
   parameter int unsigned REGIDWIDTH = 8
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [4:0]                     op,
   input  logic                           activate,
   input  logic [3:1]                     en,
   input  logic [3:1]                     squash,
   input  logic [NUMLANES*WIDTH-1:0]      opA,
   input  logic [NUMLANES*WIDTH-1:0]      opB,
   input  logic [LOG2WIDTH-1:0]           vshamt,
   input  logic [NUMLANES-1:0]            vmask,
   input  logic [REGIDWIDTH-1:0]          in_dst,
   input  logic                           in_dst_we,
   output logic                           stall,
   output logic [NUMLANES*WIDTH-1:0]      result,
   output logic [3*REGIDWIDTH-1:0]        out_dst,
   output logic [2:0]                     out_dst_we,
   output logic [3*NUMLANES-1:0]          out_dst_mask
);

   localparam int unsigned P  = NUMLANES / NUMMULS;
   localparam int unsigned GW = NUMMULS * WIDTH;
   localparam int unsigned VW = NUMLANES * WIDTH;
   localparam int unsigned PW = clog2_min1(P);

   vmul_state_e state_q, state_d;
   logic [PW-1:0] ptr_q, ptr_d, first_ptr, next_ptr;
   logic          has_next;
   logic [P-1:0]  g_q, g_d, g_new;
   logic [VW-1:0] opa_q, opa_d, opb_q, opb_d, buf_q, buf_d, result_q, result_d;
   logic          sgn_q, sgn_d, hi_q, hi_d;
   logic [GW-1:0] grp_a, grp_b, grp_res;
   logic          stall_int;

   logic [2:0][REGIDWIDTH-1:0] dst_q, dst_d;
   logic [2:0][NUMLANES-1:0]   mask_q, mask_d;
   logic [2:0]                 we_q, we_d;

`ifdef VMUL_FXP_SHIFT_EN
   logic [LOG2WIDTH-1:0] vshamt_q, vshamt_d;
   logic unused_bits;
   assign unused_bits = ^op[4:2];
`else
   logic unused_bits;
   assign unused_bits = ^{op[4:2], vshamt};
`endif

   // Group-active scan and pass-pointer stepping (descending loops leave the lowest hit).
   always_comb begin
      g_new = '0;
      for (int unsigned k = 0; k < P; k++) g_new[k] = |vmask[k*NUMMULS +: NUMMULS];
      first_ptr = '0;
      for (int unsigned k = P; k > 0; k--) begin
         if (g_new[k-1]) first_ptr = PW'(k - 1);
      end
      has_next = 1'b0;
      next_ptr = '0;
      for (int unsigned k = P; k > 0; k--) begin
         if (g_q[k-1] && ((k - 1) > 32'(ptr_q))) begin
            has_next = 1'b1;
            next_ptr = PW'(k - 1);
         end
      end
      grp_a = '0;
      grp_b = '0;
      for (int unsigned k = 0; k < P; k++) begin
         if (32'(ptr_q) == k) begin
            grp_a = opa_q[k*GW +: GW];
            grp_b = opb_q[k*GW +: GW];
         end
      end
   end

   vmul_group #(
      .NUMMULS   (NUMMULS),
      .WIDTH     (WIDTH),
      .LOG2WIDTH (LOG2WIDTH)
   ) u_group (
      .a         (grp_a),
      .b         (grp_b),
      .is_signed (sgn_q),
      .is_hi     (hi_q),
`ifdef VMUL_FXP_SHIFT_EN
      .vshamt    (vshamt_q),
`endif
      .res       (grp_res)
   );

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      g_d       = g_q;
      opa_d     = opa_q;
      opb_d     = opb_q;
      sgn_d     = sgn_q;
      hi_d      = hi_q;
      buf_d     = buf_q;
      stall_int = 1'b0;
`ifdef VMUL_FXP_SHIFT_EN
      vshamt_d  = vshamt_q;
`endif
      case (state_q)
         BUSY: begin
            stall_int = has_next;
            if (en[1]) begin
               for (int unsigned k = 0; k < P; k++) begin
                  if (32'(ptr_q) == k) buf_d[k*GW +: GW] = grp_res;
               end
               if (has_next) ptr_d = next_ptr;
               else          state_d = DONE;
            end
            if (squash[2]) state_d = IDLE;
         end
         default: begin
            // DONE doubles as an issue slot: stall is already low, so stage 1 may hold a new op.
            if (en[1]) begin
               state_d = IDLE;
               if (activate) begin
                  opa_d   = opA;
                  opb_d   = opB;
                  sgn_d   = op[OP_SIGNED];
                  hi_d    = op[OP_HI];
                  g_d     = g_new;
                  ptr_d   = first_ptr;
                  buf_d   = '0;
                  state_d = (|g_new) ? BUSY : DONE;
`ifdef VMUL_FXP_SHIFT_EN
                  vshamt_d = vshamt;
`endif
               end
            end
         end
      endcase
   end

   // Writeback pipe; stage 2 takes a bubble while stalled so stage 3 never repeats an op.
   always_comb begin
      dst_d    = dst_q;
      mask_d   = mask_q;
      we_d     = we_q;
      result_d = result_q;
      if (en[1] && !stall_int) begin
         dst_d[0]  = in_dst;
         mask_d[0] = vmask;
         we_d[0]   = in_dst_we;
      end
      if (en[2]) begin
         if (!stall_int) begin
            dst_d[1]  = dst_q[0];
            mask_d[1] = mask_q[0];
            we_d[1]   = we_q[0];
         end else begin
            we_d[1] = 1'b0;
         end
      end
      if (en[3]) begin
         dst_d[2]  = dst_q[1];
         mask_d[2] = mask_q[1];
         we_d[2]   = we_q[1];
         result_d  = buf_q;
      end
      if (squash[1]) we_d[0] = 1'b0;
      if (squash[2]) we_d[1] = 1'b0;
      if (squash[3]) we_d[2] = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         g_q      <= '0;
         opa_q    <= '0;
         opb_q    <= '0;
         sgn_q    <= 1'b0;
         hi_q     <= 1'b0;
         buf_q    <= '0;
         result_q <= '0;
         dst_q    <= '0;
         mask_q   <= '0;
         we_q     <= '0;
`ifdef VMUL_FXP_SHIFT_EN
         vshamt_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         g_q      <= g_d;
         opa_q    <= opa_d;
         opb_q    <= opb_d;
         sgn_q    <= sgn_d;
         hi_q     <= hi_d;
         buf_q    <= buf_d;
         result_q <= result_d;
         dst_q    <= dst_d;
         mask_q   <= mask_d;
         we_q     <= we_d;
`ifdef VMUL_FXP_SHIFT_EN
         vshamt_q <= vshamt_d;
`endif
      end
   end

   assign stall        = stall_int;
   assign result       = result_q;
   assign out_dst      = dst_q;
   assign out_dst_we   = we_q;
   assign out_dst_mask = mask_q;

endmodule

// File: tb/tb_vmul_unit_mp.sv
// Directed, table-driven bench for vmul_unit_mp (8 lanes, 4 multipliers, 2 passes).
module tb_vmul_unit_mp;

   logic          clk = 1'b0;
   logic          reset;
   logic [4:0]    op;
   logic          activate;
   logic [3:1]    en;
   logic [3:1]    squash;
   logic [255:0]  opA, opB;
   logic [4:0]    vshamt;
   logic [7:0]    vmask;
   logic [7:0]    in_dst;
   logic          in_dst_we;
   logic          stall;
   logic [255:0]  result;
   logic [23:0]   out_dst;
   logic [2:0]    out_dst_we;
   logic [23:0]   out_dst_mask;

   int errors = 0;
   int checks = 0;

   vmul_unit_mp #(
      .NUMLANES   (8),
      .WIDTH      (32),
      .LOG2WIDTH  (5),
      .NUMMULS    (4),
      .REGIDWIDTH (8)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .op           (op),
      .activate     (activate),
      .en           (en),
      .squash       (squash),
      .opA          (opA),
      .opB          (opB),
      .vshamt       (vshamt),
      .vmask        (vmask),
      .in_dst       (in_dst),
      .in_dst_we    (in_dst_we),
      .stall        (stall),
      .result       (result),
      .out_dst      (out_dst),
      .out_dst_we   (out_dst_we),
      .out_dst_mask (out_dst_mask)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [7:0]  mask;
      logic [7:0]  dst;
      logic        we;
      logic [4:0]  sh;
      logic [31:0] exp;
      int          stalls;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic issue_and_check(input logic [4:0] o, input logic [255:0] a, input logic [255:0] b,
                                  input logic [7:0] m, input logic [7:0] d, input logic w,
                                  input logic [4:0] s, input logic [255:0] exp_res, input int exp_stalls);
      int cnt;
      @(negedge clk);
      activate = 1'b1; op = o; opA = a; opB = b; vmask = m;
      in_dst = d; in_dst_we = w; vshamt = s;
      @(negedge clk);
      activate = 1'b0; in_dst_we = 1'b0; opA = '1; opB = '1; vmask = 8'hA5; in_dst = 8'h00;
      cnt = 0;
      while (stall && cnt < 16) begin
         cnt++;
         @(negedge clk);
      end
      check($sformatf("stall_cycles dst=%0h", d), cnt, exp_stalls);
      @(negedge clk);
      check($sformatf("we3_early dst=%0h", d), out_dst_we[2], 1'b0);
      @(negedge clk);
      check($sformatf("we3 dst=%0h", d), out_dst_we[2], w);
      check($sformatf("dst3 dst=%0h", d), out_dst[16 +: 8], d);
      check($sformatf("mask3 dst=%0h", d), out_dst_mask[16 +: 8], m);
      for (int i = 0; i < 8; i++)
         check($sformatf("lane%0d dst=%0h", i, d), result[i*32 +: 32], exp_res[i*32 +: 32]);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic [255:0] exp_full;
      logic [255:0] a_full, b_full;

      //                op        a             b             mask   dst    we    sh     exp           stalls
      vecs.push_back('{5'd0,     32'd3,        32'd5,        8'hFF, 8'h11, 1'b1, 5'd0,  32'd15,       1});
      vecs.push_back('{5'd0,     32'd3,        32'd5,        8'h0F, 8'h12, 1'b1, 5'd0,  32'd15,       0});
      vecs.push_back('{5'd0,     32'd3,        32'd5,        8'h00, 8'h13, 1'b1, 5'd0,  32'd0,        0});
      vecs.push_back('{5'd3,     32'hFFFFFFFF, 32'd2,        8'hFF, 8'h14, 1'b1, 5'd0,  32'hFFFFFFFF, 1});
      vecs.push_back('{5'd2,     32'hFFFFFFFF, 32'd2,        8'hF0, 8'h15, 1'b1, 5'd0,  32'h00000001, 0});
      vecs.push_back('{5'd1,     32'hFFFFFFFF, 32'd7,        8'h3C, 8'h16, 1'b1, 5'd0,  32'hFFFFFFF9, 1});
      vecs.push_back('{5'd0,     32'h00010000, 32'h00010000, 8'h80, 8'h17, 1'b0, 5'd0,  32'h00000000, 0});
      vecs.push_back('{5'b11101, 32'h7FFFFFFF, 32'h7FFFFFFF, 8'h01, 8'h18, 1'b1, 5'd0,  32'h00000001, 0});
`ifdef VMUL_FXP_SHIFT_EN
      vecs.push_back('{5'd1,     32'h00004000, 32'h00004000, 8'hFF, 8'h19, 1'b1, 5'd15, 32'h00002000, 1});
`endif

      reset = 1'b1; activate = 1'b0; op = '0; en = 3'b111; squash = '0;
      opA = '0; opB = '0; vshamt = '0; vmask = '0; in_dst = '0; in_dst_we = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_stall", stall, 1'b0);
      check("reset_result", result, '0);
      check("reset_we", out_dst_we, 3'b000);
      check("reset_dst", out_dst, '0);
      check("reset_mask", out_dst_mask, '0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      foreach (vecs[n]) begin
         exp_full = '0;
         for (int i = 0; i < 8; i++)
            if (|vecs[n].mask[(i/4)*4 +: 4]) exp_full[i*32 +: 32] = vecs[n].exp;
         issue_and_check(vecs[n].op, {8{vecs[n].a}}, {8{vecs[n].b}}, vecs[n].mask, vecs[n].dst,
                         vecs[n].we, vecs[n].sh, exp_full, vecs[n].stalls);
      end

      // Distinct per-lane operands, only the upper group active.
      for (int i = 0; i < 8; i++) begin
         a_full[i*32 +: 32] = 32'(i + 1);
         b_full[i*32 +: 32] = 32'd10;
      end
      exp_full = {32'd80, 32'd70, 32'd60, 32'd50, 128'd0};
      issue_and_check(5'd0, a_full, b_full, 8'hF0, 8'h21, 1'b1, 5'd0, exp_full, 0);

      // squash[2] while busy aborts the pass sequence and drops stall next cycle.
      @(negedge clk);
      activate = 1'b1; op = 5'd0; opA = {8{32'd3}}; opB = {8{32'd5}}; vmask = 8'hFF;
      in_dst = 8'h31; in_dst_we = 1'b1;
      @(negedge clk);
      activate = 1'b0; in_dst_we = 1'b0;
      check("squash_stall_pre", stall, 1'b1);
      squash = 3'b010;
      @(negedge clk);
      squash = 3'b000;
      check("squash_abort_stall", stall, 1'b0);
      repeat (4) @(negedge clk);

      // Reset in the middle of a busy instruction.
      @(negedge clk);
      activate = 1'b1; op = 5'd0; opA = {8{32'd3}}; opB = {8{32'd5}}; vmask = 8'hFF;
      in_dst = 8'h41; in_dst_we = 1'b1;
      @(negedge clk);
      activate = 1'b0; in_dst_we = 1'b0;
      check("rst_busy_stall_pre", stall, 1'b1);
      #1 reset = 1'b1;
      #1;
      check("rst_busy_stall", stall, 1'b0);
      check("rst_busy_we", out_dst_we, 3'b000);
      check("rst_busy_result", result, '0);
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      issue_and_check(5'd0, {8{32'd3}}, {8{32'd5}}, 8'hFF, 8'h42, 1'b1, 5'd0, {8{32'd15}}, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/vmul_unit_mp.md
Name: vmul_unit_mp

Overview:
- Parametrised successor to the fixed 8-lane vector multiply unit.
- NUMLANES lanes share NUMMULS physical multipliers. Lane groups are issued in multiple passes, with stall back-pressure to the vector pipeline.
- New behaviour: lane groups whose vmask bits are all zero are skipped, cutting stall cycles.
- Sits in the vector lane datapath beside the ALU/shift units; dst, we and mask are piped to writeback.

Parameters:
- NUMLANES, 8, vector lanes (power of 2).
- WIDTH, 32, element width in bits.
- LOG2WIDTH, 5, width of vshamt and shift fields.
- NUMMULS, 4, physical multipliers (power of 2, divides NUMLANES; P = NUMLANES/NUMMULS passes).
- REGIDWIDTH, 8, destination register id width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- op  in  5  op[0]=signed, op[1]=high half (MULHI), op[4:2] reserved and ignored.
- activate  in  1  instruction valid in stage 1.
- en  in  3  per-stage enable [3:1].
- squash  in  3  per-stage squash [3:1].
- opA, opB  in  NUMLANES*WIDTH  lane operands; lane i is at bits [i*WIDTH +: WIDTH].
- vshamt  in  LOG2WIDTH  fixed-point right-shift amount.
- vmask  in  NUMLANES  lane enables.
- in_dst  in  REGIDWIDTH; in_dst_we  in  1.
- stall  out  1  unit busy; the pipeline must hold stage 1.
- result  out  NUMLANES*WIDTH  stage-3 lane results.
- out_dst  out  3*REGIDWIDTH; out_dst_we  out  3; out_dst_mask  out  3*NUMLANES  per-stage pipe copies.

Behaviour:
- Reset (async, active-high):
  - FSM to IDLE.
  - stall=0, result=0, out_dst=0, out_dst_we=0, out_dst_mask=0.
  - Operand, mask and result buffers cleared.
  - Reset mid-instruction abandons it; no partial writeback.
- FSM IDLE:
  - On activate & en[1]: latch opA, opB, vmask, op and vshamt.
  - Compute group-active vector g[P-1:0], where g[k] = |vmask[k*NUMMULS +: NUMMULS].
  - Go to BUSY, with pass pointer at the lowest set g bit.
  - If g is all zero: no multiplies; pass directly to stage 2 with all-zero result; no stall.
- FSM BUSY:
  - Each cycle, the NUMMULS multipliers process the group at the pass pointer.
  - Product lands in that group's slot of the result buffer; the pointer advances to the next set g bit.
  - After the last active group: go to DONE for one cycle, then IDLE.
  - Skipped groups write 0 to their result slot.
- stall:
  - Asserted from the cycle after issue until the cycle before DONE.
  - Stall cycles = popcount(g) - 1, minimum 0.
  - P=1 never stalls.
- Arithmetic:
  - Full 2*WIDTH product, signed or unsigned per op[0].
  - op[1]=0 gives the low WIDTH bits; op[1]=1 gives the high WIDTH bits.
- Latency: result valid in stage 3, 2 cycles after the final pass (3 cycles total when P=1).
- Pipes:
  - dst, we and mask stage 1 is held while stall=1.
  - Stage 2 advances only when en[2] & ~stall.
  - out_dst_we stage n is cleared by squash[n]. A squash[2] during BUSY aborts the FSM to IDLE and drops stall the next cycle.
- en deasserted: all state frozen, including the FSM and pass pointer.
- A new activate while BUSY is illegal; it is prevented by stall, and the unit ignores it.

Optional Feature:
- VMUL_FXP_SHIFT_EN defined:
  - Stage-3 barrel shifter right-shifts the 2*WIDTH product by vshamt before WIDTH truncation.
  - The shift is arithmetic if op[0], else logical.
  - Applies only when op[1]=0.
- Not defined: no shifter; vshamt is ignored; stage 3 is a plain register.

Decomposition:
- Package vmul_pkg holds:
  - op-field bit positions (OP_SIGNED=0, OP_HI=1).
  - FSM state encoding (IDLE, BUSY, DONE).
  - Width helper functions (clog2 for the pass pointer).
- One sub-module, vmul_group: NUMMULS multipliers plus the per-group signed/hi select and the optional shifter.

Test Plan:
- NUMLANES=8, NUMMULS=4, vmask=8'hFF, opA lanes=3, opB lanes=5, op=0 -> stall high exactly 1 cycle; all lanes result=15 at stage 3.
- vmask=8'h0F, same operands -> no stall; lanes 0-3 =15, lanes 4-7 =0.
- vmask=8'h00 -> no stall, result all 0, out_dst_we follows in_dst_we.
- op=3 (signed hi), opA=32'hFFFFFFFF, opB=2 -> lane result 32'hFFFFFFFF; op=2 -> 32'h00000001.
- VMUL_FXP_SHIFT_EN, opA=16'h4000, opB=16'h4000, vshamt=15, op=1 -> result=32'h00002000.
- reset asserted during BUSY -> stall=0 and out_dst_we=0 in the same cycle; the next activate completes normally.
